match_controller: RTL

Sequencer for a two-player match on the game board. It takes the debounced start button, a slow tick enable and per-rally point reports from the play-field logic. It keeps both scores, runs a serve countdown, and decides when the match is won. It drives the 2-bit `cur_state` consumed by the display and ball datapath, and issues a one-cycle `launch` pulse that releases the ball.

---
 rtl/game_pkg.sv | 20 ++
 rtl/rise_detect.sv | 35 +++
 rtl/match_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Constants shared by the match controller, the ball datapath and the display
// decode: the 2-bit match state encoding and the winner codes.
// No ports.
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Registered rising-edge detector for a debounced button level.
// RESET_VAL sets the level the delay register assumes after reset; a value of
// 1 means a button already held through reset does not produce an edge until
// it is released and pressed again.
//
// Ports:
//   clk      in  1  rising-edge clock
//   rst      in  1  synchronous active-high reset
//   i_level  in  1  button level
//   o_rise   out 1  high while i_level is 1 and was 0 on the previous edge
// -----------------------------------------------------------------------------
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_level_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) r_level_q <= RESET_VAL;
        else     r_level_q <= i_level;
    end

    // Feeds only next-state logic in the user; not a registered output itself.
    assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
// Sequencer for a two-player match: start edge detection, serve countdown,
// score keeping and win detection. All outputs are registered.
//
// Ports:
//   clk          in  1        rising-edge clock
//   rst          in  1        synchronous active-high reset
//   start        in  1        debounced start button level
//   tick         in  1        one-cycle countdown time-base pulse
//   point_valid  in  1        one-cycle pulse: rally ended
//   point_p2     in  1        rally scorer (0 = p1, 1 = p2), qualified by point_valid
//   cur_state    out 2        IDLE=0 SERVE=1 PLAY=2 OVER=3
//   score_p1     out SCORE_W  player-1 score
//   score_p2     out SCORE_W  player-2 score
//   serve_cnt    out 4        remaining serve countdown ticks
//   serve_p2     out 1        serving side (0 = p1, 1 = p2)
//   launch       out 1        one-cycle pulse on the first PLAY cycle
//   winner       out 2        0 = none, 1 = p1, 2 = p2
// -----------------------------------------------------------------------------
module match_controller
    import game_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_TICKS = 3,
    parameter int SCORE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               tick,
    input  logic               point_valid,
    input  logic               point_p2,
    output logic [1:0]         cur_state,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [3:0]         serve_cnt,
    output logic               serve_p2,
    output logic               launch,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] LP_WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [3:0]         LP_SERVE = 4'(SERVE_TICKS);

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_score_p1, r_score_p2, w_score_p1_nxt, w_score_p2_nxt;
    logic [SCORE_W-1:0] w_scorer_inc;
    logic [3:0]         r_serve_cnt, w_serve_cnt_nxt;
    logic               r_serve_p2, w_serve_p2_nxt;
    logic               r_launch, w_launch_nxt;
    logic [1:0]         r_winner, w_winner_nxt;
    logic               w_start_rise;
    logic               w_win;
    logic               w_last_tick;

    rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
        .clk     (clk),
        .rst     (rst),
        .i_level (start),
        .o_rise  (w_start_rise)
    );

    // Scorer's score after this rally; only meaningful in PLAY with point_valid.
    assign w_scorer_inc = (point_p2 ? r_score_p2 : r_score_p1) + 1'b1;
    assign w_win        = (w_scorer_inc == LP_WIN);
    assign w_last_tick  = tick && (r_serve_cnt == 4'd1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first; otherwise unassigned paths infer latches.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE,
            ST_OVER:  if (w_start_rise) w_state_nxt = ST_SERVE;
            ST_SERVE: if (w_last_tick)  w_state_nxt = ST_PLAY;
            ST_PLAY:  if (point_valid)  w_state_nxt = w_win ? ST_OVER : ST_SERVE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the counters and outputs.
    always_comb begin
        w_score_p1_nxt  = r_score_p1;
        w_score_p2_nxt  = r_score_p2;
        w_serve_cnt_nxt = r_serve_cnt;
        w_serve_p2_nxt  = r_serve_p2;
        w_winner_nxt    = r_winner;
        w_launch_nxt    = 1'b0;
        unique case (r_state)
            ST_IDLE,
            ST_OVER: begin
                if (w_start_rise) begin
                    w_score_p1_nxt  = '0;
                    w_score_p2_nxt  = '0;
                    w_serve_cnt_nxt = LP_SERVE;
                    w_serve_p2_nxt  = 1'b0;
                    w_winner_nxt    = WIN_NONE;
                end
            end
            ST_SERVE: begin
                if (w_last_tick) begin
                    w_serve_cnt_nxt = 4'd0;
                    w_launch_nxt    = 1'b1;
                end else if (tick && r_serve_cnt != 4'd0) begin
                    w_serve_cnt_nxt = r_serve_cnt - 4'd1;
                end
            end
            ST_PLAY: begin
                // A simultaneous tick is irrelevant here: only point_valid is decoded.
                if (point_valid) begin
                    if (point_p2) w_score_p2_nxt = w_scorer_inc;
                    else          w_score_p1_nxt = w_scorer_inc;
                    if (w_win) begin
                        w_winner_nxt = point_p2 ? WIN_P2 : WIN_P1;
                    end else begin
                        w_serve_cnt_nxt = LP_SERVE;
                        w_serve_p2_nxt  = ~point_p2; // loser serves
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_serve_cnt <= 4'd0;
            r_serve_p2  <= 1'b0;
            r_launch    <= 1'b0;
            r_winner    <= WIN_NONE;
        end else begin
            r_score_p1  <= w_score_p1_nxt;
            r_score_p2  <= w_score_p2_nxt;
            r_serve_cnt <= w_serve_cnt_nxt;
            r_serve_p2  <= w_serve_p2_nxt;
            r_launch    <= w_launch_nxt;
            r_winner    <= w_winner_nxt;
        end
    end

    assign cur_state = r_state;
    assign score_p1  = r_score_p1;
    assign score_p2  = r_score_p2;
    assign serve_cnt = r_serve_cnt;
    assign serve_p2  = r_serve_p2;
    assign launch    = r_launch;
    assign winner    = r_winner;

endmodule
